// File: rtl/mult_m_seq_if.sv
// Command/result bundle between the coprocessor decoder and the sequential matrix multiplier.
// The decoder side uses the master modport; the multiplier uses slave.
interface mult_m_seq_if #(
    parameter int unsigned N = 5,
    parameter int unsigned W = 8
);
    localparam int unsigned DW = $clog2(N + 1);

    logic               start;
    logic [DW-1:0]      dim;
    logic [N*N*W-1:0]   a_in;
    logic [N*N*W-1:0]   b_in;
    logic [N*N*W-1:0]   c_out;
    logic               busy;
    logic               done;
    logic               ovf;

    modport master (
        output start, dim, a_in, b_in,
        input  c_out, busy, done, ovf
    );

    modport slave (
        input  start, dim, a_in, b_in,
        output c_out, busy, done, ovf
    );
endinterface

// File: rtl/mult_m_seq.sv
// Sequential signed matrix multiplier C = A x B, one result element per cycle,
// runtime active dimension, saturating or wrapping element results, sticky overflow.
module mult_m_seq #(
    parameter int unsigned N   = 5,
    parameter int unsigned W   = 8,
    parameter int unsigned SAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    mult_m_seq_if.slave  bus
);
    localparam int unsigned DW = $clog2(N + 1);
    localparam int unsigned SW = 2 * W + $clog2(N);
    localparam int unsigned MW = N * N * W;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StCalc = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [DW-1:0] DimMax = DW'(N);
    localparam logic [DW-1:0] DimOne = DW'(1);

    logic [1:0]           state_q;
    logic [MW-1:0]        a_q, b_q, c_q;
    logic [DW-1:0]        d_q, i_q, j_q;
    logic                 ovf_q;

    logic [DW-1:0]        dim_eff;
    logic signed [SW-1:0] sum;
    logic [SW-W:0]        sum_hi;
    logic                 elem_ovf;
    logic [W-1:0]         elem;
    logic                 last_col, last_row;

    always_comb begin
        dim_eff = bus.dim;
        if (bus.dim == '0 || bus.dim > DimMax) dim_eff = DimMax;
    end

    // N lanes, lane k forms A[i][k]*B[k][j]; lanes beyond the active dimension are masked.
    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++) begin
            logic signed [W-1:0]   av;
            logic signed [W-1:0]   bv;
            logic signed [2*W-1:0] prod;
            av   = a_q[(N*N - 1 - (int'(i_q) * N + k)) * W +: W];
            bv   = b_q[(N*N - 1 - (k * N + int'(j_q))) * W +: W];
            prod = av * bv;
            if (DW'(k) < d_q) sum = sum + SW'(prod);
        end
    end

    // The sum fits W signed bits only when all bits from W-1 upward agree.
    always_comb begin
        sum_hi   = sum[SW-1:W-1];
        elem_ovf = !((&sum_hi) || !(|sum_hi));
        elem     = sum[W-1:0];
        if (elem_ovf && SAT != 0) begin
            elem = sum[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        last_col = (j_q == d_q - DimOne);
        last_row = (i_q == d_q - DimOne);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.b_in;
                        d_q     <= dim_eff;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    c_q     <= '0;
                    ovf_q   <= 1'b0;
                    i_q     <= '0;
                    j_q     <= '0;
                    state_q <= StCalc;
                end
                StCalc: begin
                    c_q[(N*N - 1 - (int'(i_q) * N + int'(j_q))) * W +: W] <= elem;
                    if (elem_ovf) ovf_q <= 1'b1;
                    if (last_col) begin
                        j_q <= '0;
                        if (last_row) state_q <= StDone;
                        else          i_q     <= i_q + DimOne;
                    end else begin
                        j_q <= j_q + DimOne;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.c_out = c_q;
    assign bus.busy  = (state_q == StLoad) || (state_q == StCalc);
    assign bus.done  = (state_q == StDone);
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_mult_m_seq.sv
// Randomised scoreboard bench for mult_m_seq: a saturating and a wrapping instance share stimulus,
// a reference model queues expected results, and a monitor checks each done pulse.
module tb_mult_m_seq;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int MW = N * N * W;

    typedef struct packed {
        logic [MW-1:0] c;
        logic          o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_s[$];
    exp_t exp_w[$];

    always #5 clk = ~clk;

    mult_m_seq_if #(.N(N), .W(W)) bus_s ();
    mult_m_seq_if #(.N(N), .W(W)) bus_w ();

    mult_m_seq #(.N(N), .W(W), .SAT(1)) u_sat (.clk(clk), .rst(rst), .bus(bus_s));
    mult_m_seq #(.N(N), .W(W), .SAT(0)) u_wrap (.clk(clk), .rst(rst), .bus(bus_w));

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic int eff_dim(input int dim);
        return (dim == 0 || dim > N) ? N : dim;
    endfunction

    // Plain integer matrix product over the active region, then range handling per element.
    function automatic exp_t model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                   input int dim, input bit sat);
        exp_t r;
        int d;
        r = '0;
        d = eff_dim(dim);
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < d; k++) begin
                    logic signed [W-1:0] ea, eb;
                    int x, y;
                    ea = a[(N*N-1-(i*N+k))*W +: W];
                    eb = b[(N*N-1-(k*N+j))*W +: W];
                    x = ea;
                    y = eb;
                    s += x * y;
                end
                if (s > 127 || s < -128) begin
                    r.o = 1'b1;
                    if (sat) s = (s > 127) ? 127 : -128;
                end
                r.c[(N*N-1-(i*N+j))*W +: W] = 8'(s);
            end
        end
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = 8'($urandom);
        return m;
    endfunction

    function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
        logic [MW-1:0] m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = v;
        return m;
    endfunction

    function automatic logic [MW-1:0] ident();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(N*N-1-(i*N+i))*W +: W] = 8'd1;
        return m;
    endfunction

    task automatic drive(input logic s, input int dim, input logic [MW-1:0] a,
                         input logic [MW-1:0] b);
        bus_s.start = s; bus_s.dim = 3'(dim); bus_s.a_in = a; bus_s.b_in = b;
        bus_w.start = s; bus_w.dim = 3'(dim); bus_w.a_in = a; bus_w.b_in = b;
    endtask

    // Issue one operation, scramble the inputs after acceptance, optionally pulse start
    // again in cycles 3 and 26, and check latency and busy.
    task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input int dim,
                          input bit noise);
        int cyc, bad, d;
        d = eff_dim(dim);
        @(posedge clk); #1;
        drive(1'b1, dim, a, b);
        @(posedge clk);
        exp_s.push_back(model(a, b, dim, 1'b1));
        exp_w.push_back(model(a, b, dim, 1'b0));
        #1;
        drive(1'b0, $urandom_range(0, 7), rand_mat(), rand_mat());
        cyc = 1;
        bad = 0;
        while (!bus_s.done && cyc < 200) begin
            if (!bus_s.busy || !bus_w.busy) bad++;
            if (noise && (cyc == 3 || cyc == 26)) begin
                bus_s.start = 1'b1; bus_w.start = 1'b1;
                bus_s.a_in = rand_mat(); bus_w.a_in = bus_s.a_in;
            end else begin
                bus_s.start = 1'b0; bus_w.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus_s.start = 1'b0; bus_w.start = 1'b0;
        chk("latency", MW'(cyc), MW'(d * d + 2));
        chk("busy_during_op", MW'(bad), '0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && bus_s.done) begin
            chk("sat_done_expected", MW'(exp_s.size() > 0), MW'(1));
            if (exp_s.size() > 0) begin
                exp_t e;
                e = exp_s.pop_front();
                chk("sat_c_out", bus_s.c_out, e.c);
                chk("sat_ovf", MW'(bus_s.ovf), MW'(e.o));
                chk("sat_busy_at_done", MW'(bus_s.busy), '0);
            end
        end
        if (rst && bus_w.done) begin
            chk("wrap_done_expected", MW'(exp_w.size() > 0), MW'(1));
            if (exp_w.size() > 0) begin
                exp_t e;
                e = exp_w.pop_front();
                chk("wrap_c_out", bus_w.c_out, e.c);
                chk("wrap_ovf", MW'(bus_w.ovf), MW'(e.o));
            end
        end
    end

    initial begin
        logic [MW-1:0] a, b;
        int cnt;
        drive(1'b0, 5, '0, '0);
        #1;
        chk("reset_c_out", bus_s.c_out, '0);
        chk("reset_busy", MW'(bus_s.busy), '0);
        chk("reset_done", MW'(bus_s.done), '0);
        chk("reset_ovf", MW'(bus_s.ovf), '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int e = 0; e < N*N; e++) b[(N*N-1-e)*W +: W] = 8'(e + 1);
        run_op(ident(), b, 5, 1'b0);
        chk("identity_c_eq_b", bus_s.c_out, b);

        run_op(fill(8'd127), fill(8'd127), 5, 1'b0);
        chk("wrap_127_elem", MW'(bus_w.c_out[7:0]), MW'(8'h05));
        run_op(fill(8'h80), fill(8'd127), 5, 1'b0);
        chk("sat_neg_elem", MW'(bus_s.c_out[7:0]), MW'(8'h80));
        run_op(ident(), ident(), 5, 1'b0);

        for (int e = 0; e < N*N; e++) begin
            a[e*W +: W] = 8'($urandom_range(1, 255));
            b[e*W +: W] = 8'($urandom_range(1, 255));
        end
        a[(N*N-1)*W +: W] = 8'd1; a[(N*N-2)*W +: W] = 8'd2;
        a[(N*N-6)*W +: W] = 8'd3; a[(N*N-7)*W +: W] = 8'd4;
        b[(N*N-1)*W +: W] = 8'd5; b[(N*N-2)*W +: W] = 8'd6;
        b[(N*N-6)*W +: W] = 8'd7; b[(N*N-7)*W +: W] = 8'd8;
        run_op(a, b, 2, 1'b0);
        chk("dim2_c11", MW'(bus_s.c_out[(N*N-7)*W +: W]), MW'(50));

        run_op(rand_mat(), rand_mat(), 0, 1'b0);
        run_op(rand_mat(), rand_mat(), 7, 1'b0);
        run_op(rand_mat(), rand_mat(), 5, 1'b1);

        // Reset in cycle 10 of a full-size operation.
        @(posedge clk); #1;
        drive(1'b1, 5, fill(8'd3), fill(8'd3));
        @(posedge clk);
        exp_s.push_back(model(fill(8'd3), fill(8'd3), 5, 1'b1));
        exp_w.push_back(model(fill(8'd3), fill(8'd3), 5, 1'b0));
        #1 drive(1'b0, 5, '0, '0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        exp_s.delete();
        exp_w.delete();
        #1;
        chk("midrst_c_out", bus_s.c_out, '0);
        chk("midrst_busy", MW'(bus_s.busy), '0);
        chk("midrst_ovf", MW'(bus_s.ovf), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus_s.done || bus_s.busy) cnt++;
        end
        chk("midrst_no_activity", MW'(cnt), '0);
        run_op(rand_mat(), rand_mat(), 5, 1'b0);

        for (int t = 0; t < 20; t++) run_op(rand_mat(), rand_mat(), $urandom_range(0, 7), 1'b0);

        repeat (2) @(posedge clk);
        chk("queues_drained", MW'(exp_s.size() + exp_w.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
